// File: rtl/average_pkg.sv
// average_pkg: shared state type, widths and helpers
// for the averaging core's sample buffer front end.
package average_pkg;

  localparam int AVG_DATA_W = 32;
  localparam int AVG_DROP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } avg_buf_state_t;

  // Counter increment that sticks at all-ones.
  function automatic logic [AVG_DROP_W-1:0] sat_inc(
    input logic [AVG_DROP_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/avg_sdp_ram.sv
// avg_sdp_ram: simple dual-port RAM, sync write, registered read.
// Ports: clk_i, rst_ni, we_i/waddr_i/wdata_i, re_i/raddr_i, rdata_o.
module avg_sdp_ram
  import average_pkg::*;
#(
  parameter int DATA_W = AVG_DATA_W,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register holds its word whenever re_i is low,
  // which is what keeps the stream output stable on stalls.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/average_sample_buffer.sv
// average_sample_buffer: collects an N-sample frame from din/we,
// then replays it as a valid/ready/last stream (o_data/o_valid/o_last).
// Status: o_busy, o_frame_done pulse, sticky o_clamped, o_drop_cnt.
module average_sample_buffer
  import average_pkg::*;
#(
  parameter int DATA_W = AVG_DATA_W,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [DATA_W-1:0]     din,
  input  logic                  we,
  input  logic [31:0]           i_dataNum,
  output logic [DATA_W-1:0]     o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_clamped,
  output logic [AVG_DROP_W-1:0] o_drop_cnt
);

  localparam logic [31:0]     DEPTH_L = 32'(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);

  avg_buf_state_t state_q, state_d;

  // Frame length and write count need one extra bit
  // so that a full DEPTH-sample frame is representable.
  logic [ADDR_W:0]   n_lat_q, n_lat_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;

  logic valid_q, valid_d;
  logic last_q, last_d;
  logic done_q, done_d;
  logic clamped_q, clamped_d;
  logic [AVG_DROP_W-1:0] drop_q, drop_d;

  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  logic [ADDR_W:0]   wr_nxt;
  logic [ADDR_W-1:0] rd_nxt;
  logic [ADDR_W:0]   n_last;

  assign wr_nxt = wr_ptr_q + 1'b1;
  assign rd_nxt = rd_ptr_q + 1'b1;
  assign n_last = n_lat_q - 1'b1;

  avg_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (din),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    n_lat_d   = n_lat_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    valid_d   = valid_q;
    last_d    = last_q;
    done_d    = done_q;
    clamped_d = clamped_q;
    drop_d    = drop_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_raddr = rd_ptr_q;

    if (ce) begin
      done_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_dataNum != '0) begin
            if (i_dataNum > DEPTH_L) begin
              n_lat_d   = DEPTH_N;
              clamped_d = 1'b1;
            end else begin
              n_lat_d = i_dataNum[ADDR_W:0];
            end
            wr_ptr_d = '0;
            state_d  = ST_FILL;
          end
        end

        ST_FILL: begin
          if (we) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_nxt;
            if (wr_nxt == n_lat_q) begin
              rd_ptr_d = '0;
              state_d  = ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          // Any strobe here is lost, including one that
          // lands on the final handshake.
          if (we) begin
            drop_d = sat_inc(drop_q);
          end
          if (!valid_q) begin
            // First cycle of DRAIN: prime the read register.
            ram_re    = 1'b1;
            ram_raddr = rd_ptr_q;
            valid_d   = 1'b1;
            last_d    = ({1'b0, rd_ptr_q} == n_last);
          end else if (i_ready) begin
            if (last_q) begin
              valid_d = 1'b0;
              last_d  = 1'b0;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              // Fetch the next word on the accepting edge
              // so back-to-back transfers have no bubble.
              ram_re    = 1'b1;
              ram_raddr = rd_nxt;
              rd_ptr_d  = rd_nxt;
              last_d    = ({1'b0, rd_nxt} == n_last);
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      n_lat_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      clamped_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      n_lat_q   <= n_lat_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
      clamped_q <= clamped_d;
      drop_q    <= drop_d;
    end
  end

  assign o_data       = ram_rdata;
  assign o_valid      = valid_q;
  assign o_last       = last_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_frame_done = done_q;
  assign o_clamped    = clamped_q;
  assign o_drop_cnt   = drop_q;

endmodule

// File: tb/tb_average_sample_buffer.sv
// tb_average_sample_buffer: random frames checked against a
// queue-based frame model by a handshake monitor.
module tb_average_sample_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [31:0] din;
  logic        we;
  logic [31:0] i_dataNum;
  logic [31:0] o_data;
  logic        o_valid;
  logic        i_ready;
  logic        o_last;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_clamped;
  logic [7:0]  o_drop_cnt;

  average_sample_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .ce           (ce),
    .din          (din),
    .we           (we),
    .i_dataNum    (i_dataNum),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_last       (o_last),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_clamped    (o_clamped),
    .o_drop_cnt   (o_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_m;
  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int rdy_mode = 0;
  bit stall_v = 0;
  logic [31:0] stall_d;
  logic stall_l;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: looks at what the next rising edge will sample.
  always @(negedge clk) begin
    if (!reset) begin
      stall_v = 0;
    end else begin
      if (stall_v)
        chk("stall_hold", {o_valid, o_last, o_data},
            {1'b1, stall_l, stall_d});
      if (o_frame_done && ce) done_cnt++;
      if (o_valid && ce && i_ready) begin
        stall_v = 0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: got %0h want none", o_data);
        end else begin
          e_m = exp_q.pop_front();
          chk("word", {o_last, o_data}, {e_m.l, e_m.d});
          acc_cnt++;
        end
      end else if (o_valid) begin
        stall_v = 1;
        stall_d = o_data;
        stall_l = o_last;
      end else begin
        stall_v = 0;
      end
    end
  end

  initial begin
    int ph;
    ph = 0;
    i_ready = 1'b1;
    forever begin
      step();
      if (rdy_mode == 0) i_ready = 1'b1;
      else if (rdy_mode == 1) i_ready = (ph % 3 == 0);
      else if (rdy_mode == 2) i_ready = ($urandom_range(1) == 1);
      else i_ready = 1'b0;
      ph++;
    end
  end

  task automatic check_reset_vals(input string nm);
    chk(nm, {o_data, o_valid, o_last, o_busy, o_frame_done,
             o_clamped, o_drop_cnt}, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    we = 1'b0;
    ce = 1'b1;
    i_dataNum = 0;
    step();
    check_reset_vals("reset_vals");
    exp_q.delete();
    step();
    reset = 1'b1;
    step();
  endtask

  // ce low for a while: every output must stay put.
  task automatic freeze(input int cycles);
    logic [63:0] snap;
    ce = 1'b0;
    we = 1'b1;
    snap = {o_data, o_valid, o_last, o_busy, o_frame_done,
            o_drop_cnt};
    for (int i = 0; i < cycles; i++) begin
      din = $urandom;
      step();
      chk("freeze", {o_data, o_valid, o_last, o_busy,
                     o_frame_done, o_drop_cnt}, snap);
    end
    ce = 1'b1;
    we = 1'b0;
  endtask

  task automatic run_frame(input int n, input bit seq, input bit gaps,
                           input bit pause, input bit consec,
                           input bit we_drain, input int drops);
    int k, w, cyc, a0, d0;
    bit paused;
    logic [31:0] d;
    k = (n > 16) ? 16 : n;
    w = 0;
    paused = 0;
    a0 = acc_cnt;
    d0 = done_cnt;
    ce = 1'b1;
    we = 1'b0;
    i_dataNum = n;
    step();
    i_dataNum = 0;
    while (w < k) begin
      if (pause && !paused && w == 2) begin
        freeze(10);
        paused = 1;
      end
      ce = gaps ? ($urandom_range(3) != 0) : 1'b1;
      we = gaps ? ($urandom_range(1) == 1) : 1'b1;
      d = seq ? 32'(w + 1) : $urandom;
      din = d;
      if (ce && we) begin
        exp_q.push_back('{d: d, l: (w == k - 1)});
        w++;
      end
      step();
    end
    ce = 1'b1;
    we = we_drain;
    din = $urandom;
    if (consec) begin
      chk("lat_state", {o_busy, o_valid}, 2'b10);
      step();
      chk("lat_first", {o_valid, o_last}, {1'b1, k == 1});
      repeat (k) step();
      chk("throughput", {o_frame_done, 32'(acc_cnt - a0)},
          {1'b1, 32'(k)});
    end
    if (drops > 0) begin
      we = 1'b1;
      for (int i = 1; i <= drops; i++) begin
        din = $urandom;
        step();
        if (i == 10) chk("drop10", o_drop_cnt, 10);
      end
      chk("drop_sat", o_drop_cnt, 255);
      we = 1'b0;
      rdy_mode = 0;
    end
    if (pause) begin
      cyc = 0;
      while (acc_cnt - a0 < 2 && cyc < 200) begin
        step();
        cyc++;
      end
      freeze(10);
    end
    cyc = 0;
    while (done_cnt == d0 && cyc < 3000) begin
      step();
      if (we_drain) din = $urandom;
      cyc++;
    end
    we = 1'b0;
    step();
    chk("frame_done", done_cnt - d0, 1);
    chk("drained", exp_q.size(), 0);
    chk("count", acc_cnt - a0, k);
  endtask

  initial begin
    int a0, d0, cyc;
    reset = 1'b0;
    ce = 1'b1;
    we = 1'b0;
    din = 0;
    i_dataNum = 0;
    repeat (2) step();
    do_reset();

    run_frame(5, 1, 0, 0, 1, 0, 0);
    rdy_mode = 1;
    run_frame(5, 1, 0, 0, 0, 0, 0);
    rdy_mode = 0;
    run_frame(1, 0, 0, 0, 1, 0, 0);
    run_frame(16, 0, 0, 0, 1, 0, 0);
    chk("no_clamp", o_clamped, 0);
    run_frame(40, 1, 0, 0, 0, 0, 0);
    chk("clamp", o_clamped, 1);
    run_frame(8, 0, 0, 1, 0, 0, 0);
    for (int f = 0; f < 6; f++) begin
      rdy_mode = 2;
      run_frame($urandom_range(20, 1), 0, 1, 0, 0, 0, 0);
    end
    rdy_mode = 0;

    do_reset();
    rdy_mode = 3;
    run_frame(4, 0, 0, 0, 0, 0, 300);

    // One state-change cycle plus one per handshake.
    do_reset();
    run_frame(2, 0, 0, 0, 0, 1, 0);
    chk("drop_last", o_drop_cnt, 3);

    do_reset();
    a0 = acc_cnt;
    d0 = done_cnt;
    i_dataNum = 5;
    step();
    i_dataNum = 0;
    for (int i = 0; i < 5; i++) begin
      din = 32'(100 + i);
      we = 1'b1;
      exp_q.push_back('{d: 32'(100 + i), l: (i == 4)});
      step();
    end
    we = 1'b0;
    cyc = 0;
    while (acc_cnt - a0 < 2 && cyc < 200) begin
      step();
      cyc++;
    end
    chk("pre_reset_acc", acc_cnt - a0, 2);
    reset = 1'b0;
    step();
    check_reset_vals("mid_reset");
    exp_q.delete();
    reset = 1'b1;
    repeat (4) step();
    chk("no_done", done_cnt - d0, 0);
    run_frame(2, 1, 0, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/average_sample_buffer.md
# average_sample_buffer

Upstream stage of the averaging core. Collects a frame of `N` 32-bit samples from the raw `din`/`we` write strobe into an internal buffer. Once the frame is complete, replays it to the averaging core as a valid/ready stream with a last-word marker. This decouples the free-running sample source from the core's consumption rate and guarantees the core sees exactly `N` samples per frame.

## Interface
Parameters:
- `DATA_W`, 32: sample width.
- `DEPTH`, 16: buffer capacity in samples; must be a power of two, at least 2.
- `ADDR_W`, $clog2(DEPTH): buffer address width.

Ports:
- `clk`  in  1  — single clock; all logic on the rising edge.
- `reset`  in  1  — synchronous, active-low; the block is in reset while `reset`=0.
- `ce`  in  1  — clock enable. When 0, all state, counters and outputs hold.
- `din`  in  DATA_W  — sample data.
- `we`  in  1  — sample write strobe, qualified by `ce`.
- `i_dataNum`  in  32  — requested frame length `N`; sampled only in IDLE.
- `o_data`  out  DATA_W  — replayed sample to the averaging core.
- `o_valid`  out  1  — `o_data` valid.
- `i_ready`  in  1  — averaging core accepts `o_data`.
- `o_last`  out  1  — current `o_data` is the final word of the frame.
- `o_busy`  out  1  — high in FILL or DRAIN.
- `o_frame_done`  out  1  — one-cycle pulse after the last word is accepted.
- `o_clamped`  out  1  — sticky; set when `N` > DEPTH.
- `o_drop_cnt`  out  8  — saturating count of `we` strobes dropped during DRAIN.

## Operation
- FSM states: IDLE, FILL, DRAIN.
- **IDLE**
  - Waits for `ce`=1 and `i_dataNum`≠0.
  - Latches `n_lat` = min(`i_dataNum`, DEPTH). If clamped, sets `o_clamped`.
  - Clears `wr_ptr`, then moves to FILL.
  - `i_dataNum`=0 keeps the block in IDLE.
  - `we` is ignored in IDLE and is not counted as a drop.
- **FILL**
  - Each cycle with `ce`&&`we` writes `din` to `mem[wr_ptr]` and increments `wr_ptr`.
  - The write that makes the count equal `n_lat` moves the FSM to DRAIN and clears `rd_ptr`.
- **DRAIN**
  - Presents `mem[rd_ptr]` on `o_data` with `o_valid`=1.
  - `o_last`=1 when `rd_ptr`=`n_lat`-1.
  - On `o_valid`&&`i_ready`&&`ce`, advances `rd_ptr` and loads the next word.
  - On acceptance of the last word: pulses `o_frame_done`, drops `o_valid`, returns to IDLE.
- `we` during DRAIN is dropped and increments `o_drop_cnt`, saturating at 255.
- Handshake rules:
  - `o_data`, `o_valid` and `o_last` are stable while `o_valid`&&!`i_ready`.
  - `o_valid` never falls without acceptance, except on reset.
- `o_clamped` and `o_drop_cnt` are cleared only by reset.

## Timing
- Reset values:
  - FSM = IDLE.
  - `o_data`=0, `o_valid`=0, `o_last`=0, `o_busy`=0, `o_frame_done`=0, `o_clamped`=0, `o_drop_cnt`=0.
  - Pointers = 0.
- Reset has priority over `ce`. Reset mid-FILL or mid-DRAIN discards the frame; no `o_frame_done` is issued.
- Latency:
  - IDLE→FILL takes 1 cycle.
  - The first word appears (`o_valid`=1) 2 cycles after the final FILL write: one cycle for the state change, one for the registered buffer read.
  - Throughput in DRAIN is 1 word per cycle with `i_ready` held high. Output registers are prefetched so there are no bubbles.
- `o_frame_done` is high the cycle after the last handshake, coincident with the return to IDLE. A new frame may start on that same cycle, so `o_busy` goes low for one cycle only.
- `ce`=0 in any state freezes the FSM, pointers, outputs and the pulse. A pending `o_frame_done` is held until `ce` returns.
- `N`=1: the single write moves directly to DRAIN, and that word is presented with `o_last`=1.
- Simultaneous `we` and the last-word handshake in DRAIN: the write is counted as a drop.

## Structure
- Shared package `average_pkg`:
  - FSM state enum `avg_buf_state_t`.
  - `AVG_DATA_W`=32.
  - `AVG_DROP_W`=8.
- One natural sub-module, `avg_sdp_ram`:
  - Simple dual-port RAM, DEPTH×DATA_W.
  - Synchronous write, registered synchronous read.
  - Infers BRAM/LUTRAM.
- The FSM, pointers and handshake registers live in the top module.

## Test plan
- Reset then `i_dataNum`=5; write `din`=1..5 with `we` every cycle; `i_ready`=1 → `o_data` 1,2,3,4,5 on consecutive cycles; `o_last` only on 5; one `o_frame_done` pulse.
- Same frame with `i_ready` toggled 1,0,0,1,… → no word lost or duplicated; `o_data` stable during stalls.
- `i_dataNum`=40, DEPTH=16 → `o_clamped`=1; exactly 16 words drained.
- 300 `we` strobes during a DRAIN held off with `i_ready`=0 → `o_drop_cnt`=255; the buffered frame is unchanged.
- `ce`=0 for 10 cycles mid-FILL and mid-DRAIN → all outputs frozen; output sequence identical to the `ce`=1 run.
- Reset asserted at the 3rd drained word → all outputs at reset values the next cycle; a new `i_dataNum`=2 frame then completes correctly.
